// File: rtl/fuzz_stim_checker.sv
// fuzz_stim_checker: drives pseudo-random vectors onto the shared stimulus bus,
// compares y_ref_i against y_dut_i after LAT cycles, and hashes y_dut_i into a
// 32-bit MISR signature.
// Optional build macro: ZERO_INSERT_EN forces stim to zero on every
// ZERO_PERIOD-th vector without disturbing the LFSR sequence.
//
// state   | meaning
// IDLE    | waiting for start after reset
// RUN     | issuing one vector per cycle, idx 0..NUM_VEC-1
// DRAIN   | LAT cycles letting in-flight vectors reach the compare point
// DONE    | results frozen until the next start
module fuzz_stim_checker #(
  parameter int unsigned STIM_W      = 48,
  parameter int unsigned Y_W         = 127,
  parameter int unsigned NUM_VEC     = 24,
  parameter int unsigned LAT         = 0,
  parameter logic [63:0] SEED        = 64'hE965B76F25EA0C42,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ZERO_PERIOD = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [STIM_W-1:0] stim_o,
  input  logic [Y_W-1:0]    y_ref_i,
  input  logic [Y_W-1:0]    y_dut_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mismatch_o,
  output logic [CNT_W-1:0]  mismatch_count_o,
  output logic [15:0]       first_fail_idx_o,
  output logic [31:0]       signature_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [63:0] SEED_EFF   = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam int unsigned NCH        = (Y_W + 31) / 32;
  localparam logic [15:0] LAST_IDX   = 16'(NUM_VEC - 1);
  localparam logic [3:0]  DRAIN_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_t            state_q;
  logic [63:0]       lfsr_q;
  logic [15:0]       idx_q;
  logic [3:0]        drain_q;
  logic              busy_q, done_q, mismatch_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       ffi_q;
  logic [31:0]       sig_q;
  logic              cmp_vld;
  logic [15:0]       cmp_idx;
  logic              zero_vec;
  logic              start_now;
  logic              run;

  assign run       = (state_q == S_RUN);
  assign start_now = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  // XOR of the 32-bit chunks of y, the top chunk zero-padded
  function automatic logic [31:0] fold(input logic [Y_W-1:0] y);
    logic [NCH*32-1:0] p;
    logic [31:0]       r;
    p = '0;
    p[Y_W-1:0] = y;
    r = '0;
    for (int k = 0; k < NCH; k++) r = r ^ p[k*32 +: 32];
    return r;
  endfunction

`ifdef ZERO_INSERT_EN
  localparam logic [15:0] ZP_INIT = 16'(ZERO_PERIOD - 1);
  logic [15:0] zp_q;

  // phase down-counter; reaching zero marks a forced all-zero vector
  always_ff @(posedge clk_i) begin
    if (rst_i) zp_q <= ZP_INIT;
    else if (start_now) zp_q <= ZP_INIT;
    else if (run) zp_q <= (zp_q == 16'd0) ? ZP_INIT : zp_q - 16'd1;
  end

  assign zero_vec = (zp_q == 16'd0);
`else
  assign zero_vec = 1'b0;
`endif

  // stimulus is the LFSR low bits while issuing vectors, zero otherwise
  always_comb begin
    stim_o = '0;
    if (run && !zero_vec) stim_o = lfsr_q[STIM_W-1:0];
  end

  generate
    if (LAT > 0) begin : g_pipe
      logic [LAT-1:0] vld_q;
      logic [15:0]    pidx_q [LAT];

      // tags each issued vector so its compare lands LAT cycles later
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= run;
          for (int k = 1; k < LAT; k++) vld_q[k] <= vld_q[k-1];
        end
        pidx_q[0] <= idx_q;
        for (int k = 1; k < LAT; k++) pidx_q[k] <= pidx_q[k-1];
      end

      assign cmp_vld = vld_q[LAT-1];
      assign cmp_idx = pidx_q[LAT-1];
    end else begin : g_nopipe
      assign cmp_vld = run;
      assign cmp_idx = idx_q;
    end
  endgenerate

  // sequencing FSM with compare statistics and MISR
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_EFF;
      idx_q      <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
      ffi_q      <= 16'hFFFF;
      sig_q      <= 32'hFFFF_FFFF;
    end else begin
      if (cmp_vld) begin
        if (y_ref_i != y_dut_i) begin
          mismatch_q <= 1'b1;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          if (ffi_q == 16'hFFFF) ffi_q <= cmp_idx;
        end
        sig_q <= {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ fold(y_dut_i);
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q    <= S_RUN;
            lfsr_q     <= SEED_EFF;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
            ffi_q      <= 16'hFFFF;
            sig_q      <= 32'hFFFF_FFFF;
          end
        end
        S_RUN: begin
          lfsr_q <= lfsr_step(lfsr_q);
          idx_q  <= idx_q + 16'd1;
          if (idx_q == LAST_IDX) begin
            if (LAT > 0) begin
              state_q <= S_DRAIN;
              drain_q <= DRAIN_INIT;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == 4'd0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign mismatch_o       = mismatch_q;
  assign mismatch_count_o = cnt_q;
  assign first_fail_idx_o = ffi_q;
  assign signature_o      = sig_q;

endmodule
